// File: rtl/dr_seq_pkg.sv
// Shared definitions for the data-register load sequencer:
// FSM state encoding, DR function-select codes and the default address width.
package dr_seq_pkg;

  localparam int unsigned ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Data register function-select codes
  localparam logic [1:0] FS_SEXT = 2'b00;  // load byte, sign-extend
  localparam logic [1:0] FS_ZEXT = 2'b01;  // load byte, zero-extend
  localparam logic [1:0] FS_SHL  = 2'b10;  // shift left 8, insert byte
  localparam logic [1:0] FS_SHR  = 2'b11;  // shift right 8, insert byte

endpackage

// File: rtl/dr_seq_addr_gen.sv
// Byte address generator for the DR load sequencer.
// Build option: DR_SEQ_LITTLE_ENDIAN_EN selects little-endian memory layout
// (MSB at the highest address); default is big-endian (MSB at base).
// All arithmetic wraps modulo 2^ADDR_W.
module dr_seq_addr_gen
  import dr_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [2:0]        n_i,
  input  logic [2:0]        ic_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [2:0] off;

`ifndef DR_SEQ_LITTLE_ENDIAN_EN
  logic unused_n;
  assign unused_n = ^n_i;
`endif

  // Offset of byte ic from the base, then wrap-around add
  always_comb begin
`ifdef DR_SEQ_LITTLE_ENDIAN_EN
    off = n_i - 3'd1 - ic_i;
`else
    off = ic_i;
`endif
    addr_o = base_i + ADDR_W'(off);
  end

endmodule

// File: rtl/dr_load_sequencer.sv
// Sequences byte reads from synchronous memory into the byte-loaded 32-bit
// data register, assembling a 1-4 byte zero/sign-extended operand.
// Endianness is selected in dr_seq_addr_gen via DR_SEQ_LITTLE_ENDIAN_EN.
module dr_load_sequencer
  import dr_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [1:0]        Count,
  input  logic              Signed,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic              DR_E,
  output logic [1:0]        DR_FunSel
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        n_q, n_d;
  logic              sgn_q, sgn_d;
  logic [2:0]        ic_q, ic_d;
  logic [2:0]        cc_q, cc_d;
  logic [ADDR_W-1:0] gen_addr;

  dr_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .base_i (base_q),
    .n_i    (n_q),
    .ic_i   (ic_q),
    .addr_o (gen_addr)
  );

  // State and operand registers, synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      n_q     <= '0;
      sgn_q   <= 1'b0;
      ic_q    <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      n_q     <= n_d;
      sgn_q   <= sgn_d;
      ic_q    <= ic_d;
      cc_q    <= cc_d;
    end
  end

  // Next-state and output decode; outputs depend on registered state only.
  // Issue and capture run concurrently, capture trailing issue by one cycle.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    n_d       = n_q;
    sgn_d     = sgn_q;
    ic_d      = ic_q;
    cc_d      = cc_q;
    Busy      = 1'b0;
    Done      = 1'b0;
    MemRead   = 1'b0;
    DR_E      = 1'b0;
    DR_FunSel = FS_SEXT;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          base_d  = Addr;
          n_d     = {1'b0, Count} + 3'd1;
          sgn_d   = Signed;
          ic_d    = '0;
          cc_d    = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        Busy = 1'b1;
        if (ic_q < n_q) begin
          MemRead = 1'b1;
          ic_d    = ic_q + 3'd1;
        end
        if (cc_q < ic_q) begin
          DR_E      = 1'b1;
          DR_FunSel = (cc_q == 3'd0) ? (sgn_q ? FS_SEXT : FS_ZEXT) : FS_SHL;
          cc_d      = cc_q + 3'd1;
          if (cc_q + 3'd1 == n_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        Done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    MemAddr = MemRead ? gen_addr : '0;
  end

endmodule

// File: tb/tb_dr_load_sequencer.sv
// Self-checking bench for dr_load_sequencer with a byte-wide synchronous
// memory and a behavioural 32-bit byte-loaded data register.
module tb_dr_load_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] Addr;
  logic [1:0]  Count;
  logic        Signed;
  logic        Busy, Done, MemRead, DR_E;
  logic [15:0] MemAddr;
  logic [1:0]  DR_FunSel;

  logic [7:0]  mem [0:65535];
  logic [7:0]  memq;
  logic [31:0] dr;

  int n_checks = 0;
  int n_fail   = 0;

  dr_load_sequencer #(.ADDR_W(16)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Addr      (Addr),
    .Count     (Count),
    .Signed    (Signed),
    .Busy      (Busy),
    .Done      (Done),
    .MemAddr   (MemAddr),
    .MemRead   (MemRead),
    .DR_E      (DR_E),
    .DR_FunSel (DR_FunSel)
  );

  always #5 Clock = ~Clock;

  // Synchronous memory read port
  always @(posedge Clock) if (MemRead) memq <= mem[MemAddr];

  // Data register model
  always @(posedge Clock) begin
    if (DR_E) begin
      case (DR_FunSel)
        2'b00:   dr <= {{24{memq[7]}}, memq};
        2'b01:   dr <= {24'h0, memq};
        2'b10:   dr <= {dr[23:0], memq};
        default: dr <= {memq, dr[31:8]};
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " Busy"},      {31'd0, Busy},    32'd0);
    check_eq({tag, " Done"},      {31'd0, Done},    32'd0);
    check_eq({tag, " MemRead"},   {31'd0, MemRead}, 32'd0);
    check_eq({tag, " MemAddr"},   {16'd0, MemAddr}, 32'd0);
    check_eq({tag, " DR_E"},      {31'd0, DR_E},    32'd0);
    check_eq({tag, " DR_FunSel"}, {30'd0, DR_FunSel}, 32'd0);
  endtask

  // One transaction, checked cycle by cycle against the documented timeline.
  // poke: pulse Start while Busy and in the Done cycle; both must be ignored.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [1:0] cnt,
                        input logic sgn, input logic [15:0] ea [4],
                        input logic [31:0] exp_dr, input bit poke);
    int n;
    logic [1:0] efs;
    n = int'(cnt) + 1;
    Addr = a; Count = cnt; Signed = sgn; Start = 1'b1;
    cyc();
    Start = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      check_eq($sformatf("%s c%0d Busy", tag, c), {31'd0, Busy}, {31'd0, (c <= n + 1)});
      check_eq($sformatf("%s c%0d Done", tag, c), {31'd0, Done}, {31'd0, (c == n + 2)});
      check_eq($sformatf("%s c%0d MemRead", tag, c), {31'd0, MemRead}, {31'd0, (c <= n)});
      if (c <= n)
        check_eq($sformatf("%s c%0d MemAddr", tag, c), {16'd0, MemAddr}, {16'd0, ea[c-1]});
      check_eq($sformatf("%s c%0d DR_E", tag, c), {31'd0, DR_E}, {31'd0, (c >= 2 && c <= n + 1)});
      efs = (c == 2) ? (sgn ? 2'b00 : 2'b01) : ((c > 2 && c <= n + 1) ? 2'b10 : 2'b00);
      check_eq($sformatf("%s c%0d FunSel", tag, c), {30'd0, DR_FunSel}, {30'd0, efs});
      if (c == n + 2) check_eq($sformatf("%s DR", tag), dr, exp_dr);
      if (poke) begin
        Start = (c == 2 || c == n + 2);
        Addr  = 16'h0040;
      end
      cyc();
    end
    Start = 1'b0;
    check_eq($sformatf("%s after Busy", tag), {31'd0, Busy}, 32'd0);
    check_eq($sformatf("%s after MemRead", tag), {31'd0, MemRead}, 32'd0);
  endtask

  logic [15:0] ea_be [4];
  logic [15:0] ea_c1 [4];
  logic [15:0] ea_c0 [4];
  logic [15:0] ea_wr [4];
  int rises, dones, reads, overlap;
  logic prev_busy;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    memq = 8'h00;
    dr   = 32'h0;
    mem[16'h0010] = 8'h12; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h56; mem[16'h0013] = 8'h78;
`ifdef DR_SEQ_LITTLE_ENDIAN_EN
    mem[16'h0021] = 8'h80; mem[16'h0020] = 8'h12;
`else
    mem[16'h0020] = 8'h80; mem[16'h0021] = 8'h12;
`endif
    mem[16'h0030] = 8'hFF;
    mem[16'hFFFE] = 8'h01; mem[16'hFFFF] = 8'h02; mem[16'h0000] = 8'h03; mem[16'h0001] = 8'h04;
    mem[16'h0040] = 8'hAA; mem[16'h0041] = 8'hBB; mem[16'h0042] = 8'hCC; mem[16'h0043] = 8'hDD;

`ifdef DR_SEQ_LITTLE_ENDIAN_EN
    ea_be = '{16'h0013, 16'h0012, 16'h0011, 16'h0010};
    ea_c1 = '{16'h0021, 16'h0020, 16'h0000, 16'h0000};
    ea_wr = '{16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE};
`else
    ea_be = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    ea_c1 = '{16'h0020, 16'h0021, 16'h0000, 16'h0000};
    ea_wr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
`endif
    ea_c0 = '{16'h0030, 16'h0000, 16'h0000, 16'h0000};

    Reset = 1'b1; Start = 1'b0; Addr = '0; Count = '0; Signed = 1'b0;
    cyc(); cyc();
    check_all_zero("reset");
    Reset = 1'b0;
    cyc();

`ifdef DR_SEQ_LITTLE_ENDIAN_EN
    run_op("be4", 16'h0010, 2'd3, 1'b0, ea_be, 32'h78563412, 1'b0);
`else
    run_op("be4", 16'h0010, 2'd3, 1'b0, ea_be, 32'h12345678, 1'b0);
`endif
    run_op("s2",   16'h0020, 2'd1, 1'b1, ea_c1, 32'hFFFF8012, 1'b0);
    run_op("z2",   16'h0020, 2'd1, 1'b0, ea_c1, 32'h00008012, 1'b0);
    run_op("s1",   16'h0030, 2'd0, 1'b1, ea_c0, 32'hFFFFFFFF, 1'b0);
`ifdef DR_SEQ_LITTLE_ENDIAN_EN
    run_op("wrap", 16'hFFFE, 2'd3, 1'b0, ea_wr, 32'h04030201, 1'b1);
`else
    run_op("wrap", 16'hFFFE, 2'd3, 1'b0, ea_wr, 32'h01020304, 1'b1);
`endif
    for (int i = 0; i < 3; i++) check_eq($sformatf("poke idle%0d Busy", i), {31'd0, Busy}, 32'd0);

    // Reset in the middle of a 4-byte load, after two captures
    Addr = 16'h0040; Count = 2'd3; Signed = 1'b0; Start = 1'b1;
    cyc();
    Start = 1'b0;
    cyc();
    cyc();
    Reset = 1'b1;
    cyc();
    check_all_zero("midrst");
`ifdef DR_SEQ_LITTLE_ENDIAN_EN
    check_eq("midrst DR", dr, 32'h0000DDCC);
`else
    check_eq("midrst DR", dr, 32'h0000AABB);
`endif
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq($sformatf("postrst%0d DR_E", i), {31'd0, DR_E}, 32'd0);
      check_eq($sformatf("postrst%0d Busy", i), {31'd0, Busy}, 32'd0);
    end
`ifdef DR_SEQ_LITTLE_ENDIAN_EN
    check_eq("postrst DR", dr, 32'h0000DDCC);
    run_op("again", 16'h0010, 2'd3, 1'b0, ea_be, 32'h78563412, 1'b0);
`else
    check_eq("postrst DR", dr, 32'h0000AABB);
    run_op("again", 16'h0010, 2'd3, 1'b0, ea_be, 32'h12345678, 1'b0);
`endif

    // Start held high: one Done per accepted request, two reads each
    rises = 0; dones = 0; reads = 0; overlap = 0; prev_busy = 1'b0;
    Addr = 16'h0020; Count = 2'd1; Signed = 1'b0; Start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (i == 23) Start = 1'b0;
      if (Busy && !prev_busy) rises++;
      if (Done) dones++;
      if (MemRead) reads++;
      if (Done && Busy) overlap++;
      prev_busy = Busy;
    end
    check_eq("hold dones==accepts", dones, rises);
    check_eq("hold reads==2*accepts", reads, 2 * rises);
    check_eq("hold done/busy overlap", overlap, 0);
    check_eq("hold accepts>=3", {31'd0, (rises >= 3)}, 32'd1);
    check_eq("hold final Busy", {31'd0, Busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
